cache_bus_arbiter: RTL and testbench
====================================

Name: cache_bus_arbiter

Overview:
- Sits directly downstream of the instruction and data DMCache instances.
- Takes line-fill (read) and line-writeback (write) requests from both caches and serialises them onto the single system bus.
- Owns request tagging: tag carries the source (INSTR/DATA) and direction, so the caches never inspect the tag.
- One bus transaction is outstanding at a time. Lines move as 2^LOGLINEOFFSET beats of WIDTH bits.

Parameters:
- WIDTH, 64, bus beat width and address width in bits
- LOGLINEOFFSET, 3, log2 of beats per cache line (line = WIDTH<<LOGLINEOFFSET bits = 512)
- TAGW, 13, bus tag width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ireq_valid  in  1  instruction cache requests a line transfer
- ireq_write  in  1  1 = writeback, 0 = fill
- ireq_addr  in  WIDTH  line address (low LOGLINEOFFSET+3 bits ignored, driven as 0 on bus)
- ireq_wdata  in  WIDTH<<LOGLINEOFFSET  writeback line
- ireq_grant  out  1  one-cycle pulse: request accepted
- iresp_valid  out  1  one-cycle pulse: transaction complete
- iresp_data  out  WIDTH<<LOGLINEOFFSET  filled line
- dreq_valid, dreq_write, dreq_addr, dreq_wdata, dreq_grant, dresp_valid, dresp_data: same as the i* ports, for the data cache
- bus_reqcyc  out  1  bus request valid
- bus_req  out  WIDTH  address beat, then write-data beats
- bus_reqtag  out  TAGW  [TAGW-1] = write, [0] = source (0 INSTR, 1 DATA), other bits 0
- bus_reqack  in  1  bus accepted current req beat
- bus_respcyc  in  1  response beat valid
- bus_resp  in  WIDTH  response data beat
- bus_resptag  in  TAGW  response tag
- bus_respack  out  1  arbiter consumed response beat

Behaviour:
- Reset values: all outputs 0; FSM goes to IDLE; round-robin pointer favours DATA; beat counter 0. Reset mid-transaction abandons it with no resp pulse.
- Client rule: hold *_valid, *_write, *_addr and *_wdata stable from assertion until *_resp_valid. Drop valid in the cycle after resp_valid.
- Request capture: address, write flag, wdata and source are latched at grant. Later client changes are ignored.
- FSM states: IDLE, ADDR, WDATA, RWAIT, DONE.
- IDLE:
  - If one valid is high, grant it.
  - If both are high, grant the one not granted last (round-robin). The first conflict after reset goes to DATA.
  - Pulse the matching *_grant and go to ADDR next cycle.
- ADDR:
  - bus_reqcyc=1, bus_req = aligned address, bus_reqtag per format.
  - Hold until bus_reqack=1.
  - Then go to WDATA if write, else RWAIT. Beat counter = 0.
- WDATA:
  - bus_reqcyc=1, bus_req = wdata[cnt*WIDTH +: WIDTH], same tag.
  - Each reqack advances cnt.
  - After the reqack on beat 2^LOGLINEOFFSET-1, go to DONE. No response is expected for writes.
- RWAIT:
  - bus_reqcyc=0.
  - When bus_respcyc=1 and bus_resptag equals the issued tag: bus_respack=1 combinationally in the same cycle, store the beat into line[cnt*WIDTH +: WIDTH], and increment cnt.
  - Beats with a mismatching tag get no respack and are not stored.
  - After the last beat, go to DONE.
- DONE:
  - Pulse *_resp_valid for exactly one cycle to the latched source.
  - *_resp_data holds the assembled line (fill) or is unchanged (write). It stays stable until the next fill completes for that client.
  - Return to IDLE. The next grant occurs no earlier than the following cycle.
- Latency:
  - Fill, zero bus stalls: grant@T, addr beat T+1, then N response cycles, resp_valid the cycle after the last beat.
  - Write, zero bus stalls: 1 + 8 req beats, resp_valid the cycle after the last reqack.
- Boundaries:
  - reqack deasserted holds the current beat; bus_req/bus_reqtag stay stable while bus_reqcyc=1.
  - Response gaps (respcyc low) are allowed mid-line.
  - cnt wraps to 0 at line end.
  - A valid arriving while busy waits; no request is lost.

Test Plan:
- Reset held 3 cycles during RWAIT -> all outputs 0, no resp pulse, next dreq served from IDLE cleanly.
- Single ifill addr 0x1000_0047, bus acks immediately, responds 8 beats 0x11..0x88 with tag {0,..,0} -> bus_req=0x1000_0040, reqtag=0x0000, iresp_data = {0x88,...,0x11} (beat 0 in LSBs), iresp_valid one pulse.
- dreq_write addr 0x2000, wdata beats 0xA0..0xA7, reqack stalled 2 cycles on beat 3 -> beat order 0xA0..0xA7 unchanged, reqtag=0x1001, bus_req held through stall, dresp_valid pulse, no respack ever asserted.
- ireq and dreq both valid from reset, then again after completion -> DATA granted first, INSTR second, DATA third (round-robin).
- During an INSTR fill, inject a beat with tag 0x0001 -> no respack for it, not stored; the 8 correct beats still assemble exactly.
- Response with 2-cycle gaps between beats 4 and 5 -> line correct, iresp_valid exactly one cycle after beat 7.

Source files
------------

// File: rtl/cache_bus_arbiter_if.sv
// Cache-side and system-bus-side signal bundle for cache_bus_arbiter.
// The master modport is the arbiter view; the slave modport is the caches plus bus view.
interface cache_bus_arbiter_if #(
  parameter int unsigned WIDTH         = 64,
  parameter int unsigned LOGLINEOFFSET = 3,
  parameter int unsigned TAGW          = 13
);
  localparam int unsigned LINEW = WIDTH << LOGLINEOFFSET;

  logic             ireq_valid;
  logic             ireq_write;
  logic [WIDTH-1:0] ireq_addr;
  logic [LINEW-1:0] ireq_wdata;
  logic             ireq_grant;
  logic             iresp_valid;
  logic [LINEW-1:0] iresp_data;

  logic             dreq_valid;
  logic             dreq_write;
  logic [WIDTH-1:0] dreq_addr;
  logic [LINEW-1:0] dreq_wdata;
  logic             dreq_grant;
  logic             dresp_valid;
  logic [LINEW-1:0] dresp_data;

  logic             bus_reqcyc;
  logic [WIDTH-1:0] bus_req;
  logic [TAGW-1:0]  bus_reqtag;
  logic             bus_reqack;
  logic             bus_respcyc;
  logic [WIDTH-1:0] bus_resp;
  logic [TAGW-1:0]  bus_resptag;
  logic             bus_respack;

  modport master (
    input  ireq_valid, ireq_write, ireq_addr, ireq_wdata,
    output ireq_grant, iresp_valid, iresp_data,
    input  dreq_valid, dreq_write, dreq_addr, dreq_wdata,
    output dreq_grant, dresp_valid, dresp_data,
    output bus_reqcyc, bus_req, bus_reqtag,
    input  bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    output bus_respack
  );

  modport slave (
    output ireq_valid, ireq_write, ireq_addr, ireq_wdata,
    input  ireq_grant, iresp_valid, iresp_data,
    output dreq_valid, dreq_write, dreq_addr, dreq_wdata,
    input  dreq_grant, dresp_valid, dresp_data,
    input  bus_reqcyc, bus_req, bus_reqtag,
    output bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    input  bus_respack
  );
endinterface

// File: rtl/cache_bus_arbiter.sv
// Serialises instruction/data cache line fills and writebacks onto one system bus,
// one transaction at a time, with round-robin arbitration and source/direction tagging.
module cache_bus_arbiter #(
  parameter int unsigned WIDTH         = 64,
  parameter int unsigned LOGLINEOFFSET = 3,
  parameter int unsigned TAGW          = 13
) (
  input logic                 clk,
  input logic                 reset,
  cache_bus_arbiter_if.master arb
);
  localparam int unsigned BEATS = 1 << LOGLINEOFFSET;
  localparam int unsigned LINEW = WIDTH * BEATS;
  localparam logic [LOGLINEOFFSET-1:0] LAST = LOGLINEOFFSET'(BEATS - 1);
  localparam logic [WIDTH-1:0] ALIGN_MASK =
      ~((WIDTH'(1) << (LOGLINEOFFSET + 3)) - WIDTH'(1));

  typedef enum logic [2:0] {StIdle, StAddr, StWdata, StRwait, StDone} state_e;

  state_e                   state_q;
  logic                     src_q;        // 1 = data cache
  logic                     write_q;
  logic                     pref_data_q;  // who wins the next conflict
  logic [LINEW-1:0]         wdata_q;
  logic [LINEW-1:0]         line_q;
  logic [LOGLINEOFFSET-1:0] cnt_q;
  logic [TAGW-1:0]          tag_q;

  logic                     pick_data;
  logic                     pick_instr;
  logic                     resp_hit;
  logic [TAGW-1:0]          new_tag;
  logic [LINEW-1:0]         line_w;
  logic [LOGLINEOFFSET-1:0] cnt_inc;

  always_comb begin
    pick_data  = 1'b0;
    pick_instr = 1'b0;
    if (state_q == StIdle && !reset) begin
      if (arb.dreq_valid && arb.ireq_valid) begin
        pick_data  = pref_data_q;
        pick_instr = !pref_data_q;
      end else begin
        pick_data  = arb.dreq_valid;
        pick_instr = arb.ireq_valid;
      end
    end
  end

  always_comb begin
    new_tag         = '0;
    new_tag[TAGW-1] = pick_data ? arb.dreq_write : arb.ireq_write;
    new_tag[0]      = pick_data;
  end

  always_comb begin
    line_w = line_q;
    line_w[cnt_q*WIDTH +: WIDTH] = arb.bus_resp;
  end

  assign cnt_inc  = cnt_q + LOGLINEOFFSET'(1);
  assign resp_hit = (state_q == StRwait) && !reset && arb.bus_respcyc &&
                    (arb.bus_resptag == tag_q);

  assign arb.ireq_grant  = pick_instr;
  assign arb.dreq_grant  = pick_data;
  assign arb.bus_respack = resp_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      src_q           <= 1'b0;
      write_q         <= 1'b0;
      pref_data_q     <= 1'b1;
      wdata_q         <= '0;
      line_q          <= '0;
      cnt_q           <= '0;
      tag_q           <= '0;
      arb.iresp_valid <= 1'b0;
      arb.iresp_data  <= '0;
      arb.dresp_valid <= 1'b0;
      arb.dresp_data  <= '0;
      arb.bus_reqcyc  <= 1'b0;
      arb.bus_req     <= '0;
      arb.bus_reqtag  <= '0;
    end else begin
      arb.iresp_valid <= 1'b0;
      arb.dresp_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pick_data || pick_instr) begin
            src_q          <= pick_data;
            write_q        <= new_tag[TAGW-1];
            wdata_q        <= pick_data ? arb.dreq_wdata : arb.ireq_wdata;
            tag_q          <= new_tag;
            pref_data_q    <= pick_instr;
            arb.bus_reqcyc <= 1'b1;
            arb.bus_req    <= (pick_data ? arb.dreq_addr : arb.ireq_addr) & ALIGN_MASK;
            arb.bus_reqtag <= new_tag;
            state_q        <= StAddr;
          end
        end
        StAddr: begin
          if (arb.bus_reqack) begin
            cnt_q <= '0;
            if (write_q) begin
              arb.bus_req <= wdata_q[WIDTH-1:0];
              state_q     <= StWdata;
            end else begin
              arb.bus_reqcyc <= 1'b0;
              state_q        <= StRwait;
            end
          end
        end
        StWdata: begin
          if (arb.bus_reqack) begin
            if (cnt_q == LAST) begin
              cnt_q          <= '0;
              arb.bus_reqcyc <= 1'b0;
              arb.iresp_valid <= !src_q;
              arb.dresp_valid <= src_q;
              state_q        <= StDone;
            end else begin
              cnt_q       <= cnt_inc;
              arb.bus_req <= wdata_q[cnt_inc*WIDTH +: WIDTH];
            end
          end
        end
        StRwait: begin
          if (resp_hit) begin
            line_q <= line_w;
            cnt_q  <= cnt_inc;
            if (cnt_q == LAST) begin
              // Publish the line including the final beat on the same edge.
              if (src_q) arb.dresp_data <= line_w;
              else       arb.iresp_data <= line_w;
              arb.iresp_valid <= !src_q;
              arb.dresp_valid <= src_q;
              state_q         <= StDone;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed self-checking bench for cache_bus_arbiter with a scripted bus model.
module tb_cache_bus_arbiter;
  localparam int unsigned WIDTH = 64;
  localparam int unsigned LOG   = 3;
  localparam int unsigned TAGW  = 13;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  cache_bus_arbiter_if #(.WIDTH(WIDTH), .LOGLINEOFFSET(LOG), .TAGW(TAGW)) cbi ();

  cache_bus_arbiter #(.WIDTH(WIDTH), .LOGLINEOFFSET(LOG), .TAGW(TAGW)) dut (
    .clk   (clk),
    .reset (reset),
    .arb   (cbi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req_set(input bit src, input bit v, input bit w, input logic [63:0] a,
                         input logic [511:0] wd);
    if (src) begin
      cbi.dreq_valid = v; cbi.dreq_write = w; cbi.dreq_addr = a; cbi.dreq_wdata = wd;
    end else begin
      cbi.ireq_valid = v; cbi.ireq_write = w; cbi.ireq_addr = a; cbi.ireq_wdata = wd;
    end
  endtask

  function automatic logic grant_of(input bit src);
    return src ? cbi.dreq_grant : cbi.ireq_grant;
  endfunction

  function automatic logic rvalid_of(input bit src);
    return src ? cbi.dresp_valid : cbi.iresp_valid;
  endfunction

  function automatic logic [511:0] rdata_of(input bit src);
    return src ? cbi.dresp_data : cbi.iresp_data;
  endfunction

  // Starts in the IDLE cycle; returns in the IDLE cycle after DONE.
  task automatic run_fill(input bit src, input logic [63:0] addr, input logic [511:0] rline,
                          input logic [63:0] exp_addr, input logic [12:0] exp_tag,
                          input int gap_after, input bit bad_at3);
    req_set(src, 1'b1, 1'b0, addr, '0);
    #1;
    check_eq("fill_grant", grant_of(src), 1'b1);
    check_eq("fill_other_grant", grant_of(!src), 1'b0);
    cyc();
    cbi.bus_reqack = 1'b1;
    #1;
    check_eq("fill_reqcyc", cbi.bus_reqcyc, 1'b1);
    check_eq("fill_addr", cbi.bus_req, exp_addr);
    check_eq("fill_tag", cbi.bus_reqtag, exp_tag);
    cyc();
    cbi.bus_reqack = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (bad_at3 && k == 3) begin
        cbi.bus_respcyc = 1'b1;
        cbi.bus_resptag = exp_tag ^ 13'h0001;
        cbi.bus_resp    = 64'hdead_beef_dead_beef;
        #1;
        check_eq("bad_tag_noack", cbi.bus_respack, 1'b0);
        cyc();
      end
      cbi.bus_respcyc = 1'b1;
      cbi.bus_resptag = exp_tag;
      cbi.bus_resp    = rline[k*64 +: 64];
      #1;
      check_eq("respack", cbi.bus_respack, 1'b1);
      check_eq("early_resp", rvalid_of(src), 1'b0);
      check_eq("rwait_reqcyc", cbi.bus_reqcyc, 1'b0);
      cyc();
      if (k == gap_after) begin
        repeat (2) begin
          cbi.bus_respcyc = 1'b0;
          #1;
          check_eq("gap_noack", cbi.bus_respack, 1'b0);
          cyc();
        end
      end
    end
    cbi.bus_respcyc = 1'b0;
    #1;
    check_eq("fill_resp_valid", rvalid_of(src), 1'b1);
    check_eq("fill_line", rdata_of(src), rline);
    req_set(src, 1'b0, 1'b0, addr, '0);
    cyc();
    #1;
    check_eq("fill_resp_pulse", rvalid_of(src), 1'b0);
    check_eq("fill_line_hold", rdata_of(src), rline);
  endtask

  task automatic run_write(input bit src, input logic [63:0] addr, input logic [511:0] wd,
                           input logic [63:0] exp_addr, input logic [12:0] exp_tag,
                           input int stall_beat, input int stall_cycles);
    logic [511:0] prev;
    prev = rdata_of(src);
    req_set(src, 1'b1, 1'b1, addr, wd);
    // Matching-tag response traffic must never be acknowledged during a write.
    cbi.bus_respcyc = 1'b1;
    cbi.bus_resptag = exp_tag;
    #1;
    check_eq("wr_grant", grant_of(src), 1'b1);
    cyc();
    cbi.bus_reqack = 1'b1;
    #1;
    check_eq("wr_addr", cbi.bus_req, exp_addr);
    check_eq("wr_tag", cbi.bus_reqtag, exp_tag);
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (k == stall_beat) begin
        cbi.bus_reqack = 1'b0;
        for (int s = 0; s < stall_cycles; s++) begin
          #1;
          check_eq("wr_stall_beat", cbi.bus_req, wd[k*64 +: 64]);
          check_eq("wr_stall_reqcyc", cbi.bus_reqcyc, 1'b1);
          cyc();
        end
        cbi.bus_reqack = 1'b1;
      end
      #1;
      check_eq("wr_beat", cbi.bus_req, wd[k*64 +: 64]);
      check_eq("wr_beat_tag", cbi.bus_reqtag, exp_tag);
      check_eq("wr_noack", cbi.bus_respack, 1'b0);
      check_eq("wr_early_resp", rvalid_of(src), 1'b0);
    end
    cyc();
    cbi.bus_reqack  = 1'b0;
    cbi.bus_respcyc = 1'b0;
    #1;
    check_eq("wr_resp_valid", rvalid_of(src), 1'b1);
    check_eq("wr_reqcyc_off", cbi.bus_reqcyc, 1'b0);
    check_eq("wr_data_kept", rdata_of(src), prev);
    req_set(src, 1'b0, 1'b0, addr, '0);
    cyc();
    #1;
    check_eq("wr_resp_pulse", rvalid_of(src), 1'b0);
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_grants"}, {cbi.ireq_grant, cbi.dreq_grant}, 2'b00);
    check_eq({tag, "_resp_valid"}, {cbi.iresp_valid, cbi.dresp_valid}, 2'b00);
    check_eq({tag, "_reqcyc"}, cbi.bus_reqcyc, 1'b0);
    check_eq({tag, "_req"}, cbi.bus_req, 64'h0);
    check_eq({tag, "_reqtag"}, cbi.bus_reqtag, 13'h0);
    check_eq({tag, "_respack"}, cbi.bus_respack, 1'b0);
    check_eq({tag, "_idata"}, cbi.iresp_data, 512'h0);
    check_eq({tag, "_ddata"}, cbi.dresp_data, 512'h0);
  endtask

  function automatic logic [511:0] mk_line(input logic [63:0] base);
    logic [511:0] l;
    for (int k = 0; k < 8; k++) l[k*64 +: 64] = base + 64'(k);
    return l;
  endfunction

  logic [511:0] line_a;
  logic [511:0] line_b;

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    req_set(1'b0, 1'b0, 1'b0, '0, '0);
    req_set(1'b1, 1'b0, 1'b0, '0, '0);
    cbi.bus_reqack  = 1'b0;
    cbi.bus_respcyc = 1'b0;
    cbi.bus_resp    = '0;
    cbi.bus_resptag = '0;
    repeat (3) cyc();
    check_quiet("reset");
    reset = 1'b0;
    cyc();

    // Both caches requesting from reset: DATA, INSTR, DATA.
    line_a = mk_line(64'h3000_0000);
    line_b = mk_line(64'h4000_0000);
    req_set(1'b0, 1'b1, 1'b0, 64'h3000, '0);
    run_fill(1'b1, 64'h4000, line_b, 64'h4000, 13'h0001, -1, 1'b0);
    run_fill(1'b0, 64'h3000, line_a, 64'h3000, 13'h0000, -1, 1'b0);
    req_set(1'b0, 1'b1, 1'b0, 64'h3040, '0);
    run_fill(1'b1, 64'h4080, line_a, 64'h4080, 13'h0001, -1, 1'b0);
    run_fill(1'b0, 64'h3040, line_b, 64'h3040, 13'h0000, -1, 1'b0);

    // Single instruction fill, unaligned address.
    run_fill(1'b0, 64'h1000_0047,
             {64'h88, 64'h77, 64'h66, 64'h55, 64'h44, 64'h33, 64'h22, 64'h11},
             64'h1000_0040, 13'h0000, -1, 1'b0);

    // Data writeback with a 2-cycle reqack stall on beat 3.
    run_write(1'b1, 64'h2000,
              {64'hA7, 64'hA6, 64'hA5, 64'hA4, 64'hA3, 64'hA2, 64'hA1, 64'hA0},
              64'h2000, 13'h1001, 3, 2);

    // Mismatching tag injected mid-fill.
    run_fill(1'b0, 64'h7000, mk_line(64'h7700_0000), 64'h7000, 13'h0000, -1, 1'b1);

    // Response gap between beats 4 and 5.
    run_fill(1'b0, 64'h8000, mk_line(64'h8800_0000), 64'h8000, 13'h0000, 4, 1'b0);

    // Reset while waiting for fill data.
    req_set(1'b0, 1'b1, 1'b0, 64'h5000, '0);
    cyc();
    cbi.bus_reqack = 1'b1;
    cyc();
    cbi.bus_reqack  = 1'b0;
    cbi.bus_respcyc = 1'b1;
    cbi.bus_resptag = 13'h0000;
    cbi.bus_resp    = 64'h5555;
    cyc();
    cyc();
    reset = 1'b1;
    req_set(1'b0, 1'b0, 1'b0, 64'h5000, '0);
    #1;
    check_eq("mid_reset_respack", cbi.bus_respack, 1'b0);
    repeat (3) begin
      cyc();
      check_quiet("mid_reset");
    end
    reset           = 1'b0;
    cbi.bus_respcyc = 1'b0;
    cyc();
    #1;
    check_eq("post_reset_no_pulse", {cbi.iresp_valid, cbi.dresp_valid}, 2'b00);
    run_fill(1'b1, 64'h6000, mk_line(64'h6600_0000), 64'h6000, 13'h0001, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
